// File: rtl/branch_pkg.sv
// branch_pkg: branch op and FSM state encodings shared by branch_pc_unit and its bench
package branch_pkg;
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGT  = 3'd4;
  localparam logic [2:0] BR_BLE  = 3'd5;
  localparam logic [2:0] BR_BGE  = 3'd6;
  localparam logic [2:0] BR_JMP  = 3'd7;
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
endpackage

// File: rtl/branch_pc_unit_if.sv
// branch_pc_unit_if: decode-to-branch-unit handshake carrying op, word offset and comparator flags
interface branch_pc_unit_if #(parameter int PC_W = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      br_op;
  logic [PC_W-1:0] offset;
  logic            eq;
  logic            gt;
  logic            lt;
  modport master (output in_valid, br_op, offset, eq, gt, lt, input in_ready);
  modport slave (input in_valid, br_op, offset, eq, gt, lt, output in_ready);
endinterface

// File: rtl/branch_cond.sv
// branch_cond: resolves a branch op against comparator flags, flagging non-one-hot flags
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] br_op_i,
  input  logic       eq_i,
  input  logic       gt_i,
  input  logic       lt_i,
  output logic       cond_o,
  output logic       flag_err_o
);
  logic cmp;
  // conditional ops trust the flags only when exactly one is set; otherwise fall through
  always_comb begin
    cmp = br_op_i != BR_NONE && br_op_i != BR_JMP;
    flag_err_o = cmp && !$onehot({eq_i, gt_i, lt_i});
    cond_o = flag_err_o ? 1'b0 :
      br_op_i == BR_BEQ ? eq_i :
      br_op_i == BR_BNE ? !eq_i :
      br_op_i == BR_BLT ? lt_i :
      br_op_i == BR_BGT ? gt_i :
      br_op_i == BR_BLE ? (eq_i | lt_i) :
      br_op_i == BR_BGE ? (eq_i | gt_i) :
      br_op_i == BR_JMP;
  end
endmodule

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC register and branch resolver with flush bubble and halt; stats under BRANCH_STATS_EN
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              STEP     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_i,
  branch_pc_unit_if.slave  bus,
  output logic [PC_W-1:0]  pc_o,
  output logic             taken_o,
  output logic             flush_o,
  output logic             flag_err_o,
  output logic [31:0]      stat_br_o,
  output logic [31:0]      stat_tk_o
);
  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, flag_err_q, cond, err, acc, take;
  branch_cond u_cond (
    .br_op_i    (bus.br_op),
    .eq_i       (bus.eq),
    .gt_i       (bus.gt),
    .lt_i       (bus.lt),
    .cond_o     (cond),
    .flag_err_o (err)
  );
  assign bus.in_ready = state_q == ST_RUN;
  // halt drops a coincident op; a taken op redirects and costs one bubble
  always_comb begin
    acc = bus.in_valid && bus.in_ready && !halt_i;
    take = acc && cond;
    state_d = (halt_i || state_q == ST_HALTED) ? ST_HALTED : take ? ST_FLUSH : ST_RUN;
    pc_d = take ? pc_q + (bus.offset << 2) : acc ? pc_q + PC_W'(STEP) : pc_q;
  end
  // state, PC and one-cycle redirect/error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q <= RESET_PC;
      taken_q <= 1'b0;
      flag_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      taken_q <= take;
      flag_err_q <= acc && err;
    end
  end
  assign pc_o = pc_q;
  assign taken_o = taken_q;
  assign flush_o = taken_q;
  assign flag_err_o = flag_err_q;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_tk_q;
  // count accepted branch/jump ops and those that redirected, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_tk_q <= '0;
    end else begin
      if (acc && bus.br_op != BR_NONE) stat_br_q <= stat_br_q + 32'd1;
      if (take) stat_tk_q <= stat_tk_q + 32'd1;
    end
  end
  assign stat_br_o = stat_br_q;
  assign stat_tk_o = stat_tk_q;
`else
  assign stat_br_o = '0;
  assign stat_tk_o = '0;
`endif
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: vector table, hand sequences and random stimulus against a behavioural model
module tb_branch_pc_unit;
  import branch_pkg::*;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic [31:0] pc, stat_br, stat_tk;
  logic        taken, flush, ferr;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc = 32'h100;
  logic [31:0] m_br = 0;
  logic [31:0] m_tk = 0;
  logic        m_halted = 1'b0;
  logic        m_bubble = 1'b0;
  logic        e_tk, e_err;

  branch_pc_unit_if #(.PC_W(32)) bus ();

  branch_pc_unit #(.PC_W(32), .RESET_PC(32'h100), .STEP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .halt_i     (halt),
    .bus        (bus.slave),
    .pc_o       (pc),
    .taken_o    (taken),
    .flush_o    (flush),
    .flag_err_o (ferr),
    .stat_br_o  (stat_br),
    .stat_tk_o  (stat_tk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [31:0] off;
    logic [2:0]  fl;
    logic [31:0] pc;
    logic        tk;
    logic        err;
    logic        rdy;
  } vec_t;
  vec_t tv[25];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask

  // One clock: drive inputs, advance the model by the architectural rules, compare after the edge.
  task automatic cyc(input logic v, input logic [2:0] op, input logic [31:0] off,
                     input logic [2:0] fl, input logic h, input logic r);
    logic acc, c, oh;
    bus.in_valid = v;
    bus.br_op = op;
    bus.offset = off;
    {bus.eq, bus.gt, bus.lt} = fl;
    halt = h;
    rst = r;
    acc = v && !m_halted && !m_bubble && !h && !r;
    e_tk = 1'b0;
    e_err = 1'b0;
    if (r) begin
      m_pc = 32'h100;
      m_halted = 1'b0;
      m_bubble = 1'b0;
      m_br = 0;
      m_tk = 0;
    end else begin
      if (acc) begin
        oh = fl == 3'b100 || fl == 3'b010 || fl == 3'b001;
        if (op == BR_NONE) c = 1'b0;
        else if (op == BR_JMP) c = 1'b1;
        else if (!oh) begin
          c = 1'b0;
          e_err = 1'b1;
        end else
          c = op == BR_BEQ ? fl[2] : op == BR_BNE ? !fl[2] : op == BR_BLT ? fl[0] :
              op == BR_BGT ? fl[1] : op == BR_BLE ? (fl[2] | fl[0]) : (fl[2] | fl[1]);
        m_pc = c ? m_pc + off * 32'd4 : m_pc + 32'd4;
        e_tk = c;
        if (op != BR_NONE) m_br = m_br + 1;
        if (c) m_tk = m_tk + 1;
      end
      m_bubble = e_tk;
      if (h) m_halted = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("taken", {31'd0, taken}, {31'd0, e_tk});
    chk("flush", {31'd0, flush}, {31'd0, e_tk});
    chk("flag_err", {31'd0, ferr}, {31'd0, e_err});
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, !m_halted && !m_bubble});
    chk("stat_br", stat_br, STATS ? m_br : 32'd0);
    chk("stat_tk", stat_tk, STATS ? m_tk : 32'd0);
  endtask

  initial begin
    logic        v, h, r;
    logic [2:0]  op, fl;
    logic [31:0] off;
    tv[0]  = '{1'b1, BR_NONE, 32'd0,          3'b000, 32'h104,      1'b0, 1'b0, 1'b1};
    tv[1]  = '{1'b1, BR_NONE, 32'd0,          3'b000, 32'h108,      1'b0, 1'b0, 1'b1};
    tv[2]  = '{1'b1, BR_NONE, 32'd0,          3'b000, 32'h10C,      1'b0, 1'b0, 1'b1};
    tv[3]  = '{1'b1, BR_JMP,  32'd61,         3'b000, 32'h200,      1'b1, 1'b0, 1'b0};
    tv[4]  = '{1'b1, BR_BEQ,  32'hFFFFFFFE,   3'b100, 32'h200,      1'b0, 1'b0, 1'b1};
    tv[5]  = '{1'b1, BR_BEQ,  32'hFFFFFFFE,   3'b100, 32'h1F8,      1'b1, 1'b0, 1'b0};
    tv[6]  = '{1'b0, BR_NONE, 32'd0,          3'b000, 32'h1F8,      1'b0, 1'b0, 1'b1};
    tv[7]  = '{1'b1, BR_BLT,  32'd5,          3'b010, 32'h1FC,      1'b0, 1'b0, 1'b1};
    tv[8]  = '{1'b1, BR_BGE,  32'd3,          3'b100, 32'h208,      1'b1, 1'b0, 1'b0};
    tv[9]  = '{1'b0, BR_NONE, 32'd0,          3'b000, 32'h208,      1'b0, 1'b0, 1'b1};
    tv[10] = '{1'b1, BR_JMP,  32'hFFFFFFFE,   3'b000, 32'h200,      1'b1, 1'b0, 1'b0};
    tv[11] = '{1'b0, BR_NONE, 32'd0,          3'b000, 32'h200,      1'b0, 1'b0, 1'b1};
    tv[12] = '{1'b1, BR_BNE,  32'd7,          3'b011, 32'h204,      1'b0, 1'b1, 1'b1};
    tv[13] = '{1'b0, BR_NONE, 32'd0,          3'b000, 32'h204,      1'b0, 1'b0, 1'b1};
    tv[14] = '{1'b1, BR_BLE,  32'd2,          3'b001, 32'h20C,      1'b1, 1'b0, 1'b0};
    tv[15] = '{1'b0, BR_NONE, 32'd0,          3'b000, 32'h20C,      1'b0, 1'b0, 1'b1};
    tv[16] = '{1'b1, BR_BGT,  32'd4,          3'b001, 32'h210,      1'b0, 1'b0, 1'b1};
    tv[17] = '{1'b1, BR_BLE,  32'd4,          3'b110, 32'h214,      1'b0, 1'b1, 1'b1};
    tv[18] = '{1'b1, BR_JMP,  32'hFFFFFF7A,   3'b000, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0};
    tv[19] = '{1'b0, BR_NONE, 32'd0,          3'b000, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1};
    tv[20] = '{1'b1, BR_NONE, 32'd0,          3'b000, 32'h0,        1'b0, 1'b0, 1'b1};
    tv[21] = '{1'b1, BR_JMP,  32'hFFFFFFFF,   3'b000, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0};
    tv[22] = '{1'b0, BR_NONE, 32'd0,          3'b000, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1};
    tv[23] = '{1'b1, BR_JMP,  32'd1,          3'b000, 32'h0,        1'b1, 1'b0, 1'b0};
    tv[24] = '{1'b0, BR_NONE, 32'd0,          3'b000, 32'h0,        1'b0, 1'b0, 1'b1};
    cyc(1'b0, BR_NONE, 32'd0, 3'b000, 1'b0, 1'b1);
    cyc(1'b0, BR_NONE, 32'd0, 3'b000, 1'b0, 1'b1);
    chk("reset_pc", pc, 32'h100);
    chk("reset_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 25; i++) begin
      cyc(tv[i].v, tv[i].op, tv[i].off, tv[i].fl, 1'b0, 1'b0);
      chk($sformatf("tv%0d_pc", i), pc, tv[i].pc);
      chk($sformatf("tv%0d_taken", i), {31'd0, taken}, {31'd0, tv[i].tk});
      chk($sformatf("tv%0d_flag_err", i), {31'd0, ferr}, {31'd0, tv[i].err});
      chk($sformatf("tv%0d_ready", i), {31'd0, bus.in_ready}, {31'd0, tv[i].rdy});
    end
    for (int i = 0; i < 600; i++) begin
      v = $urandom_range(0, 3) != 0;
      op = 3'($urandom_range(0, 7));
      off = 32'($urandom_range(0, 63)) - 32'd32;
      fl = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) fl = 3'(3'b001 << $urandom_range(0, 2));
      h = $urandom_range(0, 59) == 0;
      r = (m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0;
      cyc(v, op, off, fl, h, r);
    end
    cyc(1'b0, BR_NONE, 32'd0, 3'b000, 1'b0, 1'b1);
    cyc(1'b1, BR_JMP, 32'h40, 3'b000, 1'b0, 1'b0);
    chk("jmp_pc", pc, 32'h200);
    cyc(1'b0, BR_NONE, 32'd0, 3'b000, 1'b0, 1'b1);
    chk("rst_in_flush_pc", pc, 32'h100);
    chk("rst_in_flush_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc(1'b1, BR_BEQ, 32'hFFFFFFFE, 3'b100, 1'b1, 1'b0);
    chk("halt_pc", pc, 32'h100);
    chk("halt_taken", {31'd0, taken}, 32'd0);
    chk("halt_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, BR_JMP, 32'd5, 3'b000, 1'b0, 1'b0);
    chk("halted_pc_frozen", pc, 32'h100);
    chk("halted_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc(1'b0, BR_NONE, 32'd0, 3'b000, 1'b0, 1'b1);
    chk("post_halt_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc(1'b1, BR_NONE, 32'd0, 3'b000, 1'b0, 1'b0);
    chk("post_halt_step", pc, 32'h104);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
